master_prefetch_interface: RTL and testbench

Upstream source stage for the valid/ready handshake pipes. It issues one-cycle-latency read requests to the master port, holds returned words in a small prefetch FIFO, and presents them as a valid/ready stream to the next pipe stage, which may be a no-patting, valid-patting, ready-patting or both-patting pipe. Request issue is credit-limited, so no returned word is ever dropped. A wrapping counter records completed output transfers.

---
 rtl/master_prefetch_interface_pkg.sv | 21 ++
 rtl/master_prefetch_interface_fifo.sv | 69 ++++++
 rtl/master_prefetch_interface.sv | 87 ++++++++
 tb/tb_master_prefetch_interface.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/master_prefetch_interface_pkg.sv
// Shared widths, defaults and helpers for the master prefetch source stage.
// The data word type is common to the FIFO and the top.
package master_prefetch_pkg;

    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    // Ceiling log2, used to size the FIFO pointers at elaboration time.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/master_prefetch_interface_fifo.sv
// Register-based prefetch FIFO: DEPTH x DATA_W storage, wrapping pointers and occupancy.
// Storage is deliberately not reset; only the bookkeeping is.
module sync_fifo_regs
    import master_prefetch_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  word_t          pushData_i,
    input  logic           pop_i,
    output logic           full_o,
    output logic           empty_o,
    output word_t          head_o,
    output logic [PTR_W:0] occ_o
);

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] wrPtr_d;
    logic [PTR_W:0]   occ_q;
    logic [PTR_W:0]   occ_d;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        occ_d   = occ_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        // A simultaneous push and pop leaves occupancy where it was.
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            occ_q   <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign occ_o   = occ_q;
    assign empty_o = (occ_q == '0);
    assign full_o  = (occ_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/master_prefetch_interface.sv
// Credit-limited read requester feeding a prefetch FIFO that drives a valid/ready stream.
// Requests depend only on registered state, so no input reaches o_master_req combinationally.
module master_prefetch_interface
    import master_prefetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    output logic              o_master_req,
    input  logic              i_master_busy,
    input  logic [DATA_W-1:0] i_master_data,
    output logic              o_master_valid,
    output logic [DATA_W-1:0] o_master_data,
    input  logic              i_master_ready,
    output logic [CNT_W-1:0]  o_xfer_cnt
);

    localparam int             PTR_W     = clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_LIMIT = (PTR_W+1)'(DEPTH);

    logic             enable_q;
    logic             enable_d;
    logic             inFlight_q;
    logic             inFlight_d;
    logic [CNT_W-1:0] xferCnt_q;
    logic [CNT_W-1:0] xferCnt_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [PTR_W:0]   occ;
    logic [PTR_W:0]   credit;
    word_t            head;

    // Words already stored plus the one on its way back; this cycle's pop is not credited.
    assign credit       = occ + {{PTR_W{1'b0}}, inFlight_q};
    assign o_master_req = enable_q && (credit < OCC_LIMIT);
    assign accept       = o_master_req && !i_master_busy;

    assign push           = inFlight_q && !fifoFull;
    assign o_master_valid = !fifoEmpty;
    assign pop            = o_master_valid && i_master_ready;
    assign o_master_data  = head;
    assign o_xfer_cnt     = xferCnt_q;

    always_comb begin
        enable_d   = i_enable;
        inFlight_d = accept;
        xferCnt_d  = xferCnt_q;
        if (pop) begin
            xferCnt_d = xferCnt_q + CNT_W'(1);
        end
    end

    // Clearing inFlight on reset discards a word returning in the cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q   <= 1'b0;
            inFlight_q <= 1'b0;
            xferCnt_q  <= '0;
        end else begin
            enable_q   <= enable_d;
            inFlight_q <= inFlight_d;
            xferCnt_q  <= xferCnt_d;
        end
    end

    sync_fifo_regs #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pushData_i (i_master_data),
        .pop_i      (pop),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .head_o     (head),
        .occ_o      (occ)
    );

endmodule

// File: tb/tb_master_prefetch_interface.sv
// Self-checking bench for master_prefetch_interface: directed phases plus a random phase,
// checked every cycle against a queue-based model of the master/FIFO/stream protocol.
module tb_master_prefetch_interface;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_master_busy;
    logic        i_master_ready;
    logic [31:0] i_master_data;

    logic        o_master_req;
    logic        o_master_valid;
    logic [31:0] o_master_data;
    logic [15:0] o_xfer_cnt;

    logic        wrapReq;
    logic        wrapValid;
    logic [31:0] wrapData;
    logic [3:0]  wrapCnt;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    // Reference model state: stored words, one outstanding request flag, enable delay, handshakes.
    logic [31:0] mFifo[$];
    logic        mPending = 1'b0;
    logic        mEn      = 1'b0;
    int          mCount   = 0;
    logic [31:0] nextWord = 32'h100;
    logic        sawAccept;

    int acceptCount;
    int reqHighCount;

    always #5 clk = ~clk;

    master_prefetch_interface #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (i_enable),
        .o_master_req   (o_master_req),
        .i_master_busy  (i_master_busy),
        .i_master_data  (i_master_data),
        .o_master_valid (o_master_valid),
        .o_master_data  (o_master_data),
        .i_master_ready (i_master_ready),
        .o_xfer_cnt     (o_xfer_cnt)
    );

    master_prefetch_interface #(.DEPTH(DEPTH), .CNT_W(4)) dutWrap (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (i_enable),
        .o_master_req   (wrapReq),
        .i_master_busy  (i_master_busy),
        .i_master_data  (i_master_data),
        .o_master_valid (wrapValid),
        .o_master_data  (wrapData),
        .i_master_ready (i_master_ready),
        .o_xfer_cnt     (wrapCnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle against the model, advance the model.
    task automatic applyStimulus(input logic en, input logic busy, input logic rdy, input logic rs);
        logic eReq;
        logic eValid;
        rst            = rs;
        i_enable       = en;
        i_master_busy  = busy;
        i_master_ready = rdy;
        if (mPending) begin
            i_master_data = nextWord;
            nextWord      = nextWord + 32'd1;
        end else begin
            i_master_data = $urandom;
        end
        @(negedge clk);
        eReq   = mEn && ((mFifo.size() + (mPending ? 1 : 0)) < DEPTH);
        eValid = (mFifo.size() != 0);
        checkOutput("req", 32'(o_master_req), 32'(eReq));
        checkOutput("valid", 32'(o_master_valid), 32'(eValid));
        if (eValid) begin
            checkOutput("data", o_master_data, mFifo[0]);
        end
        checkOutput("xferCnt", 32'(o_xfer_cnt), 32'(mCount % 65536));
        checkOutput("xferCntWrap", 32'(wrapCnt), 32'(mCount % 16));
        sawAccept = o_master_req && !i_master_busy;
        if (rs) begin
            mFifo.delete();
            mPending = 1'b0;
            mEn      = 1'b0;
            mCount   = 0;
        end else begin
            if (eValid && rdy) begin
                mFifo.delete(0);
                mCount++;
            end
            if (mPending) begin
                mFifo.push_back(i_master_data);
            end
            mPending = eReq && !busy;
            mEn      = en;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        i_enable       = 1'b0;
        i_master_busy  = 1'b0;
        i_master_ready = 1'b0;
        i_master_data  = 32'h0;
        @(posedge clk);
        #1;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("resetReq", 32'(o_master_req), 32'd0);
        checkOutput("resetValid", 32'(o_master_valid), 32'd0);
        checkOutput("resetCnt", 32'(o_xfer_cnt), 32'd0);

        $display("[TB] steady streaming");
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] credit stall");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0);
        acceptCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 0, 0);
            if (sawAccept) acceptCount++;
        end
        checkOutput("stallAccepts", 32'(acceptCount), 32'(DEPTH));
        checkOutput("stallReq", 32'(o_master_req), 32'd0);
        checkOutput("stallValid", 32'(o_master_valid), 32'd1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] busy hold");
        reqHighCount = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 1, 0);
            if (o_master_req) reqHighCount++;
        end
        checkOutput("busyReqHeld", 32'(reqHighCount), 32'd10);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] full FIFO with toggling ready");
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1'(i % 2), 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] reset mid-stream");
        applyStimulus(1, 0, 1, 1);
        checkOutput("midRstReq", 32'(o_master_req), 32'd0);
        checkOutput("midRstValid", 32'(o_master_valid), 32'd0);
        checkOutput("midRstCnt", 32'(o_xfer_cnt), 32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] counter wrap");
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 80 && mCount < 17; i++) applyStimulus(1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrap17", 32'(wrapCnt), 32'd1);
        checkOutput("noWrap17", 32'(o_xfer_cnt), 32'd17);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
